// File: rtl/sirius_pkg.sv
// sirius_pkg: shared types for the sirius data memory.
//   word_t       - 32-bit data word
//   be_t         - 4-bit byte-lane enable (bit i covers bits 8i+7..8i)
//   dmem_state_e - request FSM states of sirius_dmem
//   merge_bytes  - replaces the enabled byte lanes of a word
package sirius_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w, input be_t be);
    word_t r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sirius_byte_ram.sv
// sirius_byte_ram: DEPTH_WORDS x 32 storage, one independent byte RAM per lane.
//   clk_i   - clock; writes commit on the rising edge
//   we_i    - write strobe
//   be_i    - byte-lane enables for the write
//   addr_i  - word index (shared by read and write)
//   wdata_i - write word
//   rdata_o - combinational read of the word at addr_i
// Contents are never reset.
module sirius_byte_ram
  import sirius_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] lane_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
      if (we_i && be_i[b]) lane_q[addr_i] <= wdata_i[8*b +: 8];
    end

    assign rdata_o[8*b +: 8] = lane_q[addr_i];
  end

endmodule

// File: rtl/sirius_dmem.sv
// sirius_dmem: single-port CPU data memory with programmable wait states.
//   clk        - clock
//   rst        - asynchronous active-low reset
//   data_en    - request valid (taken only while idle)
//   data_wen   - byte write enables; 0000 is a read
//   data_addr  - byte address; bits [1:0] ignored
//   data_wdata - write data
//   data_rdata - response word (merged word for writes), held between responses
//   data_ok    - one-cycle response strobe, WAIT_CYCLES+1 cycles after accept
//   data_err   - out-of-range flag qualified by data_ok
// Build option: define SIRIUS_DMEM_OOB_ERR_EN to add data_err and treat
// word addresses >= DEPTH_WORDS as out of range (write suppressed, rdata 0).
// Without it the upper address bits are ignored and addresses wrap.
module sirius_dmem
  import sirius_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok
`ifdef SIRIUS_DMEM_OOB_ERR_EN
  ,
  output logic        data_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Last value of the wait counter before moving on to RESP.
  localparam logic [3:0] WLAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e   state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  be_t           wen_q;
  word_t         wdata_q;
  logic          oob_q;
  word_t         rdata_q;
  logic          ok_q;

  word_t         ram_rdata;
  word_t         rdata_d;
  logic          oob_d;
  logic          ram_we;

  // Address bits that never select a word; the OOB build also reads the upper ones.
  logic unused_addr;
  assign unused_addr = ^{data_addr[31:AW+2], data_addr[1:0]};

`ifdef SIRIUS_DMEM_OOB_ERR_EN
  logic err_q;
  // DEPTH_WORDS is a power of two, so any set bit above the index is out of range.
  assign oob_d    = |data_addr[31:AW+2];
  assign data_err = err_q;
`else
  assign oob_d = 1'b0;
`endif

  // Write merge happens against the combinational read of the latched word,
  // so the response and the committed word are the same value.
  assign rdata_d = merge_bytes(ram_rdata, wdata_q, wen_q);
  assign ram_we  = (state_q == RESP) && !oob_q;

  sirius_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .be_i   (wen_q),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
      ok_q    <= 1'b0;
`ifdef SIRIUS_DMEM_OOB_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_en) begin
            idx_q   <= data_addr[AW+1:2];
            wen_q   <= data_wen;
            wdata_q <= data_wdata;
            oob_q   <= oob_d;
            cnt_q   <= '0;
            state_q <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (cnt_q == WLAST) state_q <= RESP;
          else                cnt_q   <= cnt_q + 4'd1;
        end
        RESP: begin
          ok_q    <= 1'b1;
          rdata_q <= oob_q ? '0 : rdata_d;
`ifdef SIRIUS_DMEM_OOB_ERR_EN
          err_q   <= oob_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_rdata = rdata_q;
  assign data_ok    = ok_q;

endmodule

// File: doc/sirius_dmem.md
SIRIUS_DMEM -- requirements
Module: sirius_dmem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: wait states inserted before each response; range 0..15.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port data_en  input  1: request valid from CPU.
REQ-006 SHALL have port data_wen  input  4: byte write enables, one bit per byte lane; bit i covers bits 8i+7..8i; 0000 means read.
REQ-007 SHALL have port data_addr  input  32: byte address.
REQ-008 SHALL have port data_wdata  input  32: write data.
REQ-009 SHALL have port data_rdata  output  32: response word.
REQ-010 SHALL have port data_ok  output  1: one-cycle response strobe.
REQ-011 SHALL have port data_err  output  1: out-of-range flag, qualified by data_ok; present only with SIRIUS_DMEM_OOB_ERR_EN.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 SHALL accept a request only when data_en=1 in IDLE; data_en in WAIT or RESP is ignored, with no queuing.
REQ-014 On accept, SHALL latch data_addr, data_wen and data_wdata, then go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-015 In WAIT, SHALL count WAIT_CYCLES cycles, then go to RESP; inputs in WAIT do not affect the latched request.
REQ-016 In RESP, SHALL assert data_ok for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be WAIT_CYCLES+1 cycles from the accept edge to data_ok high; peak throughput is one request per WAIT_CYCLES+2 cycles.
REQ-018 Word index SHALL be the latched data_addr[log2(DEPTH_WORDS)+1:2]; data_addr[1:0] is ignored, so there are no alignment checks.
REQ-019 Writes SHALL update only the enabled byte lanes, committed on the RESP edge; disabled lanes keep their old value.
REQ-020 data_rdata SHALL be the addressed word after the write merge, so a write returns the merged word and a read returns the stored word.
REQ-021 data_rdata SHALL update only together with data_ok and hold its value until the next data_ok.
REQ-022 A request accepted in the cycle after data_ok SHALL see the prior write, with no stale read-after-write.

Reset
REQ-023 While rst=0: state=IDLE, wait counter=0, data_ok=0, data_rdata=0, data_err=0.
REQ-024 Reset mid-operation SHALL abandon the pending request; no memory write occurs and no data_ok is produced after release.
REQ-025 Memory contents SHALL NOT be reset.

Configuration
REQ-026 Macro SIRIUS_DMEM_OOB_ERR_EN defined: data_addr[31:2] >= DEPTH_WORDS is out-of-range.
REQ-027 Out-of-range with the macro defined: write suppressed, data_rdata=0, data_err=1 with data_ok; in-range responses give data_err=0.
REQ-028 Macro not defined: no data_err port; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS words.

Structure
REQ-029 Package sirius_pkg SHALL hold word_t (32-bit), byte-enable type be_t (4-bit) and the dmem state enum (IDLE/WAIT/RESP).
REQ-030 Storage SHALL be sub-module sirius_byte_ram: DEPTH_WORDS x 32, synchronous byte-enabled write, combinational read; the FSM stays in sirius_dmem.

Verification
REQ-031 WAIT_CYCLES=0: write addr 0x10, wen 1111, wdata 0xDEADBEEF -> data_ok 1 cycle later, rdata 0xDEADBEEF; then a read of 0x10 returns 0xDEADBEEF.
REQ-032 Byte lanes: word 0x10 holds 0xDEADBEEF; write wen 0101, wdata 0x11223344 -> rdata 0xDE22BE44.
REQ-033 WAIT_CYCLES=3: read accepted at edge N -> data_ok high at edge N+4 only; data_en pulses during WAIT are ignored and produce no extra data_ok.
REQ-034 rst driven low during WAIT of a write to 0x20 -> outputs 0 at once, no data_ok after release; a later read of 0x20 returns the old value.
REQ-035 DEPTH_WORDS=1024, write to 0x1000: macro on -> data_err=1, rdata=0, word 0 unchanged; macro off -> word 0 is written.
REQ-036 Unaligned read of 0x13 -> returns the word at 0x10.
